// File: rtl/mfp_ram_fifo_controller.sv
// FIFO controller around an external simple dual-port RAM with 1-cycle registered read.
// A 2-entry output buffer absorbs the read latency so the stream sustains one word per cycle.
module mfp_ram_fifo_controller #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic                  pending;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] tail_data;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign ram_count = wr_ptr - rd_ptr;
    assign ram_full  = (ram_count == DEPTH);
    assign ram_empty = (ram_count == '0);

    assign in_ready  = !reset && !ram_full;
    assign push      = in_valid && in_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head_data;
    assign pop       = out_valid && out_ready;

    // Buffer occupancy once this cycle's capture and pop land; a read is only
    // issued when one slot will still be free for its data next cycle.
    assign occ_next = occ + {1'b0, pending} - {1'b0, pop};
    assign issue    = !ram_empty && (occ_next <= 2'd1);

    assign count = {1'b0, ram_count}
                 + (ADDR_WIDTH+2)'(pending)
                 + (ADDR_WIDTH+2)'(occ);

    assign ram_write_enable = push;
    assign ram_write_addr   = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_write_data   = in_data;
    assign ram_read_addr    = rd_ptr[ADDR_WIDTH-1:0];

    // Stage boundary: pointers, in-flight read flag and buffer occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            pending <= issue;
            occ     <= occ_next;
        end
    end

    // Stage boundary: RAM read data lands in the buffer tail, head shifts on pop.
    always_ff @(posedge clk) begin
        case ({pop, pending})
            2'b10: begin
                head_data <= tail_data;
            end
            2'b01: begin
                if (occ == 2'd0) begin
                    head_data <= ram_read_data;
                end else begin
                    tail_data <= ram_read_data;
                end
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_data <= ram_read_data;
                end else begin
                    head_data <= tail_data;
                    tail_data <= ram_read_data;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mfp_ram_fifo_controller.sv
// Bench for mfp_ram_fifo_controller with a 4-word RAM: directed vector table,
// reset/streaming sequences and a randomized scoreboard run.
module tb_mfp_ram_fifo_controller;

    localparam int AW = 2;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic          ram_write_enable;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data;

    logic [DW-1:0] mem [4];

    int checks;
    int failures;
    int hazard_errs;
    logic mon_en;

    mfp_ram_fifo_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .count            (count),
        .ram_write_addr   (ram_write_addr),
        .ram_write_data   (ram_write_data),
        .ram_write_enable (ram_write_enable),
        .ram_read_addr    (ram_read_addr),
        .ram_read_data    (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM: one write port, registered read port.
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= mem[ram_read_addr];
    end

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (ram_write_enable && dut.issue && (ram_write_addr == ram_read_addr))
                hazard_errs++;
            if (dut.occ > 2'd2)
                hazard_errs++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        int            e_cnt;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int n_in;
        int n_out;
        int rc;
        int pend;
        int occ_m;
        int push_i;
        int pop_i;
        int issue_i;
        logic [DW-1:0] sb [$];
        logic [DW-1:0] exp_head;

        // latency: one word into an empty FIFO, then pop
        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 1};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 1};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 0};
        // fill with out_ready low: 4 in RAM + 2 in buffer, words 6 and 7 refused
        vecs[5]  = '{1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 0};
        vecs[6]  = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0, 1};
        vecs[7]  = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'd0, 2};
        vecs[8]  = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd0, 3};
        vecs[9]  = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd0, 4};
        vecs[10] = '{1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 32'd0, 5};
        vecs[11] = '{1'b1, 32'd6, 1'b0, 1'b0, 1'b1, 32'd0, 6};
        vecs[12] = '{1'b1, 32'd7, 1'b0, 1'b0, 1'b1, 32'd0, 6};
        // drain
        vecs[13] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 6};
        vecs[14] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd1, 5};
        vecs[15] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd2, 4};
        vecs[16] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3, 3};
        vecs[17] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4, 2};
        vecs[18] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd5, 1};
        vecs[19] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 0};

        checks = 0;
        failures = 0;
        hazard_errs = 0;
        mon_en = 1'b0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_we", 64'(ram_write_enable), 64'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // directed vector table
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d_we", i), 64'(ram_write_enable), 64'(vecs[i].iv & vecs[i].e_ir));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_od));
        end

        // reset mid-stream with 5 words held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 32'h100 + 32'(i);
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("midrst_count_before", 64'(count), 64'd5);
        reset = 1'b1;
        in_valid = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_we", 64'(ram_write_enable), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_release_ready", 64'(in_ready), 64'd1);
        check("midrst_release_count", 64'(count), 64'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h77;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("midrst_first_valid", 64'(out_valid), 64'd1);
        check("midrst_first_data", 64'(out_data), 64'h77);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("midrst_empty_count", 64'(count), 64'd0);

        // streaming: push and pop every cycle
        n_in = 0;
        n_out = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 32'hA000 + 32'(n_in);
            out_ready = 1'b1;
            #1;
            check($sformatf("stream%0d_count", c), 64'(count), 64'((c < 3) ? c : 3));
            check($sformatf("stream%0d_out_valid", c), 64'(out_valid), 64'(c >= 3));
            if (out_valid) begin
                check($sformatf("stream%0d_data", c), 64'(out_data), 64'(32'hA000 + 32'(n_out)));
                n_out++;
            end
            if (in_ready) n_in++;
        end
        check("stream_pops", 64'(n_out), 64'd197);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                check($sformatf("stream_drain%0d_data", c), 64'(out_data), 64'(32'hA000 + 32'(n_out)));
                n_out++;
            end
        end
        check("stream_drain_count", 64'(count), 64'd0);
        check("stream_total", 64'(n_out), 64'(n_in));

        // randomized backpressure with wrap-around against a cycle model
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rc = 0;
        pend = 0;
        occ_m = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < ((c < 5000) ? 70 : 35));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < ((c < 5000) ? 35 : 70));
            #1;
            check($sformatf("rand%0d_count", c), 64'(count), 64'(rc + pend + occ_m));
            check($sformatf("rand%0d_in_ready", c), 64'(in_ready), 64'(rc != 4));
            check($sformatf("rand%0d_out_valid", c), 64'(out_valid), 64'(occ_m != 0));
            if (occ_m != 0) begin
                exp_head = (sb.size() > 0) ? sb[0] : 32'hBAD0BAD0;
                check($sformatf("rand%0d_data", c), 64'(out_data), 64'(exp_head));
            end
            push_i  = (in_valid && rc != 4) ? 1 : 0;
            pop_i   = (occ_m != 0 && out_ready) ? 1 : 0;
            issue_i = (rc != 0 && (occ_m + pend - pop_i) <= 1) ? 1 : 0;
            if (push_i == 1) sb.push_back(in_data);
            if (pop_i == 1 && sb.size() > 0) void'(sb.pop_front());
            rc    = rc + push_i - issue_i;
            occ_m = occ_m + pend - pop_i;
            pend  = issue_i;
        end

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("hazard_and_occ", 64'(hazard_errs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
